axi_burst_writer: RTL and testbench

//  Downstream of the DDR address generator. Takes one chunk (start address + burst count) per

---
 rtl/axi_burst_writer.sv | 208 ++++++++++++++++++++
 tb/tb_axi_burst_writer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_writer.sv
// AXI4 INCR write-burst issuer: one chunk of fixed-length bursts per start pulse, with B tracking.
// Optional BRESP error counter is built when AXI_WR_BRESP_CNT_EN is defined.
module axi_burst_writer #(
    parameter int DATA_WIDTH      = 64,
    parameter int BURST_LENGTH    = 15,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [31:0]             addr,
    input  logic [31:0]             nbursts,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             err_cnt,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [31:0]             m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);

    localparam int BYTES_PER_BEAT  = DATA_WIDTH / 8;
    localparam int BYTES_PER_BURST = (BURST_LENGTH + 1) * BYTES_PER_BEAT;
    localparam int BURST_SHIFT     = $clog2(BYTES_PER_BURST);

    localparam logic [31:0] ADDR_MASK   = ~((32'd1 << BURST_SHIFT) - 32'd1);
    localparam logic [31:0] BURST_BYTES = 32'(BYTES_PER_BURST);
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_LENGTH);
    localparam logic [2:0]  AW_SIZE     = 3'($clog2(BYTES_PER_BEAT));
    localparam logic [24:0] MAX_OUT     = 25'(MAX_OUTSTANDING);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [24:0] nb_q, nb_d;
    logic [24:0] aw_cnt_q, aw_cnt_d;
    logic [24:0] w_cnt_q, w_cnt_d;
    logic [24:0] b_cnt_q, b_cnt_d;
    logic [7:0]  beat_q, beat_d;
    logic        err_q, err_d;
    logic        done_q, done_d;

    logic        start_idle;
    logic        start_go;
    logic        start_zero;
    logic        aw_hs;
    logic        w_hs;
    logic        b_hs;
    logic        b_err;
    logic        last_b;
    logic        w_ok;
    logic        unused_nb_hi;

    assign unused_nb_hi = ^nbursts[31:25];

    assign start_idle = start && (state_q == S_IDLE);
    assign start_go   = start_idle && (nbursts[24:0] != 25'd0);
    assign start_zero = start_idle && (nbursts[24:0] == 25'd0);

    assign aw_hs  = m_awvalid && m_awready;
    assign w_hs   = m_wvalid && m_wready;
    assign b_hs   = m_bvalid && m_bready;
    assign b_err  = b_hs && (m_bresp != 2'b00);
    assign last_b = b_hs && ((b_cnt_q + 25'd1) == nb_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_go) state_d = S_RUN;
            S_RUN:   if (last_b)   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // W is only allowed for bursts whose AW has already been accepted.
    always_comb begin
        busy      = (state_q == S_RUN);
        w_ok      = (state_q == S_RUN) && (w_cnt_q < aw_cnt_q);
        m_awvalid = (state_q == S_RUN) && (aw_cnt_q < nb_q)
                    && ((aw_cnt_q - b_cnt_q) < MAX_OUT);
        m_bready  = (state_q == S_RUN);
        m_wvalid  = s_valid && w_ok;
        s_ready   = m_wready && w_ok;
    end

    always_comb begin
        awaddr_d = awaddr_q;
        nb_d     = nb_q;
        aw_cnt_d = aw_cnt_q;
        w_cnt_d  = w_cnt_q;
        b_cnt_d  = b_cnt_q;
        beat_d   = beat_q;
        err_d    = err_q;
        done_d   = last_b || start_zero;
        if (start_idle) begin
            awaddr_d = addr & ADDR_MASK;
            nb_d     = nbursts[24:0];
            aw_cnt_d = 25'd0;
            w_cnt_d  = 25'd0;
            b_cnt_d  = 25'd0;
            beat_d   = 8'd0;
            err_d    = 1'b0;
        end else begin
            if (aw_hs) begin
                aw_cnt_d = aw_cnt_q + 25'd1;
                awaddr_d = awaddr_q + BURST_BYTES;
            end
            if (w_hs) begin
                if (beat_q == LAST_BEAT) begin
                    beat_d  = 8'd0;
                    w_cnt_d = w_cnt_q + 25'd1;
                end else begin
                    beat_d  = beat_q + 8'd1;
                end
            end
            if (b_hs) begin
                b_cnt_d = b_cnt_q + 25'd1;
            end
            if (b_err) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            awaddr_q <= 32'd0;
            nb_q     <= 25'd0;
            aw_cnt_q <= 25'd0;
            w_cnt_q  <= 25'd0;
            b_cnt_q  <= 25'd0;
            beat_q   <= 8'd0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            awaddr_q <= awaddr_d;
            nb_q     <= nb_d;
            aw_cnt_q <= aw_cnt_d;
            w_cnt_q  <= w_cnt_d;
            b_cnt_q  <= b_cnt_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

`ifdef AXI_WR_BRESP_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (start_idle) begin
            err_cnt_d = 16'd0;
        end else if (b_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0000;
`endif

    assign done      = done_q;
    assign err       = err_q;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = LAST_BEAT;
    assign m_awsize  = AW_SIZE;
    assign m_awburst = 2'b01;
    assign m_wdata   = s_data;
    assign m_wstrb   = '1;
    assign m_wlast   = (beat_q == LAST_BEAT);

endmodule

// File: tb/tb_axi_burst_writer.sv
// Scoreboard bench for axi_burst_writer: chunk-level reference model feeds queues, a negedge
// monitor pops and compares on every AW/W/B/done event. Honours AXI_WR_BRESP_CNT_EN.
module tb_axi_burst_writer;

    localparam int DW     = 64;
    localparam int BL     = 15;
    localparam int MO     = 4;
    localparam int BEATS  = BL + 1;
    localparam int BPB    = BEATS * (DW / 8);
    localparam int AWSIZE = $clog2(DW / 8);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   addr = 32'd0;
    logic [31:0]   nbursts = 32'd0;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   err_cnt;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   m_awaddr;
    logic [7:0]    m_awlen;
    logic [2:0]    m_awsize;
    logic [1:0]    m_awburst;
    logic          m_awvalid;
    logic          m_awready = 1'b0;
    logic [DW-1:0] m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic          m_wlast;
    logic          m_wvalid;
    logic          m_wready = 1'b0;
    logic [1:0]    m_bresp = 2'b00;
    logic          m_bvalid = 1'b0;
    logic          m_bready;

    axi_burst_writer #(
        .DATA_WIDTH(DW), .BURST_LENGTH(BL), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .addr(addr), .nbursts(nbursts),
        .busy(busy), .done(done), .err(err), .err_cnt(err_cnt),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0]   exp_aw_q[$];
    logic [DW-1:0] exp_wd_q[$];
    bit            exp_wl_q[$];
    int            exp_derr_q[$];
    int            exp_dcnt_q[$];
    logic [DW-1:0] src_q[$];
    logic [1:0]    bresp_tbl[256];

    int aw_acc = 0, b_acc = 0, w_beats = 0, w_bursts = 0, done_cnt = 0;
    int b_pending = 0, b_credit = 1000000, b_idx = 0, err_run = 0, cnt_run = 0;
    bit chk_err_next = 0, bp = 0;
    bit aw_hs_s = 0, w_hs_s = 0, wl_hs_s = 0, b_hs_s = 0;

    task automatic check(input string name, input bit ok, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] exp_cnt(input int c);
`ifdef AXI_WR_BRESP_CNT_EN
        return (c > 65535) ? 16'hFFFF : 16'(c);
`else
        return (c < 0) ? 16'hFFFF : 16'h0000;
`endif
    endfunction

    // Monitor: sampled mid-cycle, when inputs and combinational outputs are settled.
    initial begin
        logic [31:0]   ea;
        logic [DW-1:0] ed;
        bit            el;
        int            aw_before, ee, ec;
        forever begin
            @(negedge clk);
            aw_hs_s = 0; w_hs_s = 0; wl_hs_s = 0; b_hs_s = 0;
            if (rstn) begin
                aw_before = aw_acc;
                if (chk_err_next) begin
                    chk_err_next = 0;
                    check("err_after_b", err == err_run[0], err, err_run);
                    check("err_cnt_after_b", err_cnt == exp_cnt(cnt_run), err_cnt, exp_cnt(cnt_run));
                end
                if (m_awvalid && m_awready) begin
                    aw_hs_s = 1;
                    check("aw_outstanding", (aw_acc - b_acc) < MO, aw_acc - b_acc, MO);
                    if (exp_aw_q.size() == 0) begin
                        check("aw_unexpected", 1'b0, m_awaddr, 0);
                    end else begin
                        ea = exp_aw_q.pop_front();
                        check("aw_addr", m_awaddr == ea, m_awaddr, ea);
                    end
                    check("aw_attr", {m_awlen, m_awsize, m_awburst} == {8'(BL), 3'(AWSIZE), 2'b01},
                          {m_awlen, m_awsize, m_awburst}, {8'(BL), 3'(AWSIZE), 2'b01});
                    aw_acc++;
                end
                if (m_wvalid && m_wready) begin
                    w_hs_s = 1;
                    if (w_beats % BEATS == 0)
                        check("w_after_aw", w_bursts < aw_before, w_bursts, aw_before);
                    if (exp_wd_q.size() == 0) begin
                        check("w_unexpected", 1'b0, m_wdata, 0);
                    end else begin
                        ed = exp_wd_q.pop_front();
                        el = exp_wl_q.pop_front();
                        check("w_data", m_wdata == ed, m_wdata, ed);
                        check("w_last", m_wlast == el, m_wlast, el);
                    end
                    check("w_strb", &m_wstrb, m_wstrb, {(DW/8){1'b1}});
                    w_beats++;
                    if (m_wlast) begin
                        wl_hs_s = 1;
                        w_bursts++;
                    end
                end
                if (m_bvalid && m_bready) begin
                    b_hs_s = 1;
                    b_acc++;
                    if (m_bresp != 2'b00) begin
                        err_run = 1;
                        cnt_run++;
                    end
                    chk_err_next = 1;
                end
                if (done) begin
                    done_cnt++;
                    if (exp_derr_q.size() == 0) begin
                        check("done_unexpected", 1'b0, done, 0);
                    end else begin
                        ee = exp_derr_q.pop_front();
                        ec = exp_dcnt_q.pop_front();
                        check("done_err", err == ee[0], err, ee);
                        check("done_err_cnt", err_cnt == exp_cnt(ec), err_cnt, exp_cnt(ec));
                        check("done_busy", busy == 1'b0, busy, 0);
                    end
                end
            end
        end
    end

    // Bus functional driver: source stream, AW/W ready, B responder.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                s_valid  = 1'b0;
                m_bvalid = 1'b0;
            end else begin
                if (w_hs_s && src_q.size() > 0) void'(src_q.pop_front());
                if (wl_hs_s) b_pending++;
                if (b_hs_s) begin
                    b_pending--;
                    b_idx++;
                    if (b_credit > 0) b_credit--;
                end
                if (!s_valid || w_hs_s)
                    s_valid = (src_q.size() > 0) && (!bp || $urandom_range(0, 3) != 0);
                if (src_q.size() == 0) s_valid = 1'b0;
                s_data = (src_q.size() > 0) ? src_q[0] : '0;
                if (!m_bvalid || b_hs_s) begin
                    m_bvalid = (b_pending > 0) && (b_credit > 0) && (!bp || $urandom_range(0, 2) != 0);
                    m_bresp  = bresp_tbl[b_idx % 256];
                end
            end
            m_awready = !bp || ($urandom_range(0, 2) != 0);
            m_wready  = !bp || ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: a chunk is nb bursts at aligned base + i*BPB, BEATS beats each,
    // last flag on every BEATS-th beat, one done whose err/err_cnt summarise the B table.
    task automatic issue_chunk(input logic [31:0] a, input int nb);
        logic [31:0]   base;
        logic [DW-1:0] d;
        int            e_err, e_cnt;
        @(posedge clk);
        #2;
        base = (a / 32'(BPB)) * 32'(BPB);
        for (int i = 0; i < nb; i++) begin
            exp_aw_q.push_back(base + 32'(i * BPB));
            for (int j = 0; j < BEATS; j++) begin
                d = {$urandom, $urandom};
                src_q.push_back(d);
                exp_wd_q.push_back(d);
                exp_wl_q.push_back(j == BEATS - 1);
            end
        end
        e_err = 0;
        e_cnt = 0;
        for (int i = 0; i < nb; i++) begin
            if (bresp_tbl[i] != 2'b00) begin
                e_err = 1;
                e_cnt++;
            end
        end
        exp_derr_q.push_back(e_err);
        exp_dcnt_q.push_back(e_cnt);
        aw_acc = 0; b_acc = 0; b_idx = 0; w_beats = 0; w_bursts = 0;
        err_run = 0; cnt_run = 0; chk_err_next = 0;
        start = 1'b1;
        addr = a;
        nbursts = 32'(nb);
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0, n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", done_cnt != d0, done_cnt, d0 + 1);
        check("drained", exp_aw_q.size() + exp_wd_q.size() + exp_derr_q.size() == 0,
              exp_aw_q.size() + exp_wd_q.size() + exp_derr_q.size(), 0);
        $display("chunk complete: aw=%0d beats=%0d bresp=%0d err=%0b err_cnt=%0d cycles=%0d",
                 aw_acc, w_beats, b_acc, err, err_cnt, n);
    endtask

    task automatic clear_bresp();
        for (int i = 0; i < 256; i++) bresp_tbl[i] = 2'b00;
    endtask

    task automatic check_reset_outputs(input string name);
        logic [6:0] v;
        v = {busy, done, err, m_awvalid, m_wvalid, m_bready, s_ready};
        check(name, v == 7'd0, v, 0);
        check({name, "_err_cnt"}, err_cnt == 16'd0, err_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        clear_bresp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #2;
        rstn = 1'b1;

        // Basic chunk, all readies high.
        issue_chunk(32'h0000_1000, 3);
        @(negedge clk);
        check("busy_after_start", busy == 1'b1, busy, 1);
        wait_done(500);

        // Empty chunk: done one cycle later, no bus activity.
        issue_chunk(32'h0000_2000, 0);
        @(negedge clk);
        check("zero_done", done == 1'b1, done, 1);
        check("zero_busy", busy == 1'b0, busy, 0);
        @(negedge clk);
        check("zero_done_drop", done == 1'b0, done, 0);
        check("zero_busy_after", busy == 1'b0, busy, 0);
        check("zero_no_activity", aw_acc + w_beats == 0, aw_acc + w_beats, 0);

        // B withheld: outstanding limit, then one AW per released B.
        b_credit = 0;
        issue_chunk(32'h0004_0040, 10);
        repeat (120) @(posedge clk);
        @(negedge clk);
        check("aw_limit_count", aw_acc == MO, aw_acc, MO);
        check("aw_limit_valid", m_awvalid == 1'b0, m_awvalid, 0);
        for (int k = 1; k <= 10 - MO; k++) begin
            @(posedge clk);
            #2;
            b_credit = 1;
            repeat (40) @(posedge clk);
            @(negedge clk);
            check("aw_after_release", aw_acc == MO + k, aw_acc, MO + k);
        end
        @(posedge clk);
        #2;
        b_credit = 1000000;
        wait_done(1000);

        // Random backpressure and occasional error responses.
        bp = 1;
        for (int i = 0; i < 128; i++)
            bresp_tbl[i] = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
        issue_chunk($urandom, 128);
        wait_done(40000);
        bp = 0;
        clear_bresp();

        // Third response of five is SLVERR.
        bresp_tbl[2] = 2'b10;
        issue_chunk(32'h0010_0000, 5);
        wait_done(1000);
        check("err_held_after_done", err == 1'b1, err, 1);
        clear_bresp();
        issue_chunk(32'h0010_0800, 1);
        @(negedge clk);
        check("err_cleared_on_start", err == 1'b0, err, 0);
        check("err_cnt_cleared_on_start", err_cnt == 16'd0, err_cnt, 0);
        wait_done(500);

        // Reset during beat 7 of burst 2.
        issue_chunk(32'h0020_0000, 4);
        n = 0;
        while (w_beats < BEATS + 8 && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("reset_point_reached", w_beats >= BEATS + 8, w_beats, BEATS + 8);
        rstn = 1'b0;
        src_q.delete();
        exp_aw_q.delete();
        exp_wd_q.delete();
        exp_wl_q.delete();
        exp_derr_q.delete();
        exp_dcnt_q.delete();
        b_pending = 0;
        chk_err_next = 0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset_state");
        @(posedge clk);
        #2;
        rstn = 1'b1;
        issue_chunk(32'h0030_0000, 2);
        wait_done(500);

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
